countdown_timer_core: RTL and testbench
=======================================

// Module: countdown_timer_core
// PURPOSE
//  Consumer of the periodic tick from the clock-multiplier divider: an MM:SS BCD countdown timer.
//  Loads minutes/seconds from SW, counts down one second per tick, pauses/resumes, flags expiry.
//  Sits between the tick generator and the HEX/LEDR drivers in the Timer top level.
// PARAMETERS
//  MAX_MIN   59   largest loadable minutes value (BCD-clamped)
//  BLINK_DIV 2    expired LED toggles every BLINK_DIV ticks
// PORTS
//  CLOCK_50   in   1  system clock; sole clock domain
//  reset      in   1  asynchronous, active-high reset
//  tick       in   1  one-cycle 1 Hz enable from divider, synchronous to CLOCK_50
//  key_set_n  in   1  raw active-low set button, asynchronous
//  key_tog_n  in   1  raw active-low start/pause button, asynchronous
//  sw         in   8  load value: sw[7:4] tens digit, sw[3:0] ones digit (BCD)
//  min_bcd    out  8  minutes, two BCD digits
//  sec_bcd    out  8  seconds, two BCD digits
//  running    out  1  high in RUN
//  expired    out  1  high in EXPIRED
//  blink      out  1  toggles in EXPIRED at BLINK_DIV ticks, else 0
//  set_field  out  1  0 = next set press loads seconds, 1 = minutes
// BEHAVIOUR
//  - Reset: min_bcd=0, sec_bcd=0, state IDLE, running=0, expired=0, blink=0, set_field=0.
//  - Buttons: 2-FF synchroniser + falling-edge detect -> one-cycle pulse 3 cycles after press edge.
//  - States: IDLE, RUN, PAUSE, EXPIRED.
//  - set pulse (IDLE/PAUSE/EXPIRED): load sw into field set_field selects, then invert set_field;
//    EXPIRED -> IDLE on set. Ignored in RUN. Load lands next cycle.
//  - Load clamping: tens>5 -> 5, ones>9 -> 9; minutes further clamped to MAX_MIN.
//  - tog pulse: IDLE/PAUSE -> RUN if time != 00:00, else stay; RUN -> PAUSE; EXPIRED -> IDLE
//    (time stays 00:00).
//  - In RUN, tick decrements by 1 s: ones digit 0 borrows from tens; SS 00 -> 59 with MM-1.
//  - Decrement reaching 00:00 -> EXPIRED same edge; running falls, expired rises next cycle.
//  - Same-cycle tick + tog in RUN: tog wins, no decrement, -> PAUSE.
//  - Same-cycle set + tog: set processed, tog dropped.
//  - tick outside RUN ignored except blink counting in EXPIRED.
//  - Reset mid-count: all state cleared immediately (async), no partial decrement.
//  - Outputs registered; no combinational path from inputs to outputs.
// STRUCTURE
//  - timer_defs.vh: `define state encodings (2 bits), BCD limits 5/9, default MAX_MIN.
//  - Sub-module key_edge (sync + falling-edge pulse), instantiated twice.
//  - Core: one FSM always block + one BCD countdown datapath block.
// TESTING
//  1. reset pulse mid-RUN at 03:27 -> all outputs 0 within same cycle, state IDLE.
//  2. sw=8'h45 set, sw=8'h02 set -> 02:45, set_field back to 0; sw=8'h7C set -> sec 59.
//  3. 01:00, tog, 1 tick -> 00:59; 59 more ticks -> 00:00, expired=1, running=0.
//  4. RUN at 00:10, tick + tog same cycle -> PAUSE, time stays 00:10; ticks ignored.
//  5. tog at 00:00 in IDLE -> stays IDLE; key bounce of one cycle low -> one pulse only.
//  6. EXPIRED, 4 ticks at BLINK_DIV=2 -> blink toggles twice; set -> IDLE, blink=0.

Source files
------------

// File: rtl/countdown_timer_core_pkg.sv
// Shared definitions for the MM:SS countdown timer.
// Contents: FSM state encoding, BCD digit limits, default minutes limit,
// and small BCD helper functions used by the core datapath.
package countdown_timer_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] BCD_TENS_MAX    = 4'd5;
    localparam logic [3:0] BCD_ONES_MAX    = 4'd9;
    localparam int         DEFAULT_MAX_MIN = 59;

    // Force each digit of a raw switch value into a legal MM/SS digit range.
    function automatic logic [7:0] clamp_digits(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = (v[7:4] > BCD_TENS_MAX) ? BCD_TENS_MAX : v[7:4];
        ones = (v[3:0] > BCD_ONES_MAX) ? BCD_ONES_MAX : v[3:0];
        return {tens, ones};
    endfunction

    // Binary value of a two-digit BCD field whose digits are already clamped (<= 59).
    function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
        return ({3'b000, v[7:4]} * 7'd10) + {3'b000, v[3:0]};
    endfunction

    function automatic logic [7:0] bin_to_bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    // One-step BCD decrement of a 00..59 field; 00 wraps to 59 (the caller
    // detects the borrow by checking for 00 before the decrement).
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] != 4'd0)
            return {v[7:4], v[3:0] - 4'd1};
        else if (v[7:4] != 4'd0)
            return {v[7:4] - 4'd1, BCD_ONES_MAX};
        else
            return {BCD_TENS_MAX, BCD_ONES_MAX};
    endfunction

endpackage

// File: rtl/countdown_timer_core_key_edge.sv
// Push-button conditioner: two-flop synchroniser followed by a falling-edge
// detector. A press (high -> low) produces a single registered one-cycle
// pulse three clock edges after the input edge.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-high reset
//   key_n  in  raw active-low button, asynchronous to clk
//   pulse  out one-cycle pulse per falling edge of key_n
module countdown_timer_core_key_edge (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pulse
);

    // sync[0], sync[1] are the synchroniser; sync[2] holds the previous
    // synchronised level for edge detection. Idle level is high, so reset
    // to ones to avoid a spurious pulse after reset.
    logic [2:0] sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= 3'b111;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[1:0], key_n};
            pulse <= sync[2] & ~sync[1];
        end
    end

endmodule

// File: rtl/countdown_timer_core.sv
// MM:SS BCD countdown timer driven by a 1 Hz tick enable.
// Loads minutes/seconds from sw via the set button, starts/pauses with the
// toggle button, counts down one second per tick and flags expiry with a
// blinking indicator.
// Ports:
//   CLOCK_50   in  system clock
//   reset      in  asynchronous active-high reset
//   tick       in  one-cycle 1 Hz enable
//   key_set_n  in  raw active-low set button
//   key_tog_n  in  raw active-low start/pause button
//   sw         in  load value, sw[7:4] tens, sw[3:0] ones (BCD)
//   min_bcd    out minutes, two BCD digits
//   sec_bcd    out seconds, two BCD digits
//   running    out high while counting
//   expired    out high once the count has reached 00:00
//   blink      out toggles every BLINK_DIV ticks while expired
//   set_field  out 0: next set loads seconds, 1: next set loads minutes
module countdown_timer_core
    import countdown_timer_core_pkg::*;
#(
    parameter int MAX_MIN   = DEFAULT_MAX_MIN,
    parameter int BLINK_DIV = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       tick,
    input  logic       key_set_n,
    input  logic       key_tog_n,
    input  logic [7:0] sw,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       expired,
    output logic       blink,
    output logic       set_field
);

    localparam logic [6:0] MAX_MIN_BIN = 7'(MAX_MIN);
    localparam logic [7:0] MAX_MIN_BCD = bin_to_bcd(MAX_MIN);
    localparam int         CNT_W       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic             set_pulse;
    logic             tog_pulse;
    state_t           state;
    logic [CNT_W-1:0] blink_cnt;

    logic       do_load;
    logic       do_tog;
    logic       do_tick;
    logic       decrement;
    logic [7:0] sw_clamped;
    logic [7:0] min_load;
    logic [7:0] sec_next;
    logic [7:0] min_next;
    logic       sec_borrow;
    logic       next_zero;
    logic       time_zero;

    countdown_timer_core_key_edge u_key_set (
        .clk   (CLOCK_50),
        .reset (reset),
        .key_n (key_set_n),
        .pulse (set_pulse)
    );

    countdown_timer_core_key_edge u_key_tog (
        .clk   (CLOCK_50),
        .reset (reset),
        .key_n (key_tog_n),
        .pulse (tog_pulse)
    );

    // Event priority: a set press always swallows a simultaneous toggle
    // (even in RUN, where the set itself is ignored); a toggle swallows a
    // simultaneous tick.
    always_comb begin
        do_load    = set_pulse && (state != ST_RUN);
        do_tog     = tog_pulse && !set_pulse;
        do_tick    = tick && !do_load && !do_tog;
        decrement  = do_tick && (state == ST_RUN);

        sw_clamped = clamp_digits(sw);
        min_load   = (bcd_to_bin(sw_clamped) > MAX_MIN_BIN) ? MAX_MIN_BCD : sw_clamped;

        sec_borrow = (sec_bcd == 8'h00);
        sec_next   = bcd_dec(sec_bcd);
        min_next   = sec_borrow ? bcd_dec(min_bcd) : min_bcd;
        next_zero  = (min_next == 8'h00) && (sec_next == 8'h00);
        time_zero  = (min_bcd == 8'h00) && (sec_bcd == 8'h00);
    end

    // Control FSM; status outputs are registered alongside the state.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            running   <= 1'b0;
            expired   <= 1'b0;
            blink     <= 1'b0;
            blink_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_PAUSE: begin
                    if (do_tog && !time_zero) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (do_tog) begin
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                    end else if (decrement && next_zero) begin
                        state     <= ST_EXPIRED;
                        running   <= 1'b0;
                        expired   <= 1'b1;
                        blink     <= 1'b0;
                        blink_cnt <= '0;
                    end
                end
                ST_EXPIRED: begin
                    if (do_load || do_tog) begin
                        state   <= ST_IDLE;
                        expired <= 1'b0;
                        blink   <= 1'b0;
                    end else if (do_tick) begin
                        if (blink_cnt == CNT_LAST) begin
                            blink_cnt <= '0;
                            blink     <= ~blink;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                    expired <= 1'b0;
                    blink   <= 1'b0;
                end
            endcase
        end
    end

    // BCD time registers and load-field selector.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            min_bcd   <= 8'h00;
            sec_bcd   <= 8'h00;
            set_field <= 1'b0;
        end else if (do_load) begin
            if (set_field)
                min_bcd <= min_load;
            else
                sec_bcd <= sw_clamped;
            set_field <= ~set_field;
        end else if (decrement) begin
            sec_bcd <= sec_next;
            min_bcd <= min_next;
        end
    end

endmodule

// File: tb/tb_countdown_timer_core.sv
// Self-checking bench for countdown_timer_core: directed scenarios with
// literal expectations, then randomized stimulus compared every cycle
// against a behavioural model that keeps time as a plain seconds count.
module tb_countdown_timer_core;

    localparam int MAX_MIN   = 59;
    localparam int BLINK_DIV = 2;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_EXP   = 3;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       tick;
    logic       key_set_n;
    logic       key_tog_n;
    logic [7:0] sw;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       expired;
    logic       blink;
    logic       set_field;

    int total = 0;
    int bad   = 0;

    // Model state
    int m_state;
    int m_t;
    bit m_field;
    bit m_blink;
    int m_bcnt;
    bit set_h[4];
    bit tog_h[4];

    countdown_timer_core #(
        .MAX_MIN   (MAX_MIN),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .tick      (tick),
        .key_set_n (key_set_n),
        .key_tog_n (key_tog_n),
        .sw        (sw),
        .min_bcd   (min_bcd),
        .sec_bcd   (sec_bcd),
        .running   (running),
        .expired   (expired),
        .blink     (blink),
        .set_field (set_field)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [7:0] bcd8(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_t     = 0;
        m_field = 0;
        m_blink = 0;
        m_bcnt  = 0;
        for (int i = 0; i < 4; i++) begin
            set_h[i] = 1'b1;
            tog_h[i] = 1'b1;
        end
    endtask

    task automatic model_step(input bit sp, input bit tp, input bit tk, input logic [7:0] swv);
        int tens;
        int ones;
        int v;
        if (sp && m_state != S_RUN) begin
            tens = (swv[7:4] > 5) ? 5 : int'(swv[7:4]);
            ones = (swv[3:0] > 9) ? 9 : int'(swv[3:0]);
            v = tens * 10 + ones;
            if (m_field) begin
                if (v > MAX_MIN) v = MAX_MIN;
                m_t = v * 60 + (m_t % 60);
            end else begin
                m_t = (m_t / 60) * 60 + v;
            end
            m_field = !m_field;
            if (m_state == S_EXP) begin
                m_state = S_IDLE;
                m_blink = 0;
            end
        end else if (tp && !sp) begin
            case (m_state)
                S_IDLE, S_PAUSE: if (m_t != 0) m_state = S_RUN;
                S_RUN:           m_state = S_PAUSE;
                default: begin
                    m_state = S_IDLE;
                    m_blink = 0;
                end
            endcase
        end else if (tk) begin
            if (m_state == S_RUN) begin
                m_t = m_t - 1;
                if (m_t == 0) begin
                    m_state = S_EXP;
                    m_bcnt  = 0;
                    m_blink = 0;
                end
            end else if (m_state == S_EXP) begin
                m_bcnt = m_bcnt + 1;
                if (m_bcnt == BLINK_DIV) begin
                    m_bcnt  = 0;
                    m_blink = !m_blink;
                end
            end
        end
    endtask

    // Model update at each active edge, then compare just after it.
    always @(posedge CLOCK_50) begin
        bit sp;
        bit tp;
        if (reset) begin
            model_reset();
        end else begin
            // Button press takes effect four edges after the first low sample.
            sp = set_h[3] & ~set_h[2];
            tp = tog_h[3] & ~tog_h[2];
            model_step(sp, tp, tick, sw);
            for (int i = 3; i > 0; i--) begin
                set_h[i] = set_h[i-1];
                tog_h[i] = tog_h[i-1];
            end
            set_h[0] = key_set_n;
            tog_h[0] = key_tog_n;
        end
        #1;
        check("cyc_min",     min_bcd,          bcd8(m_t / 60));
        check("cyc_sec",     sec_bcd,          bcd8(m_t % 60));
        check("cyc_running", {7'd0, running},   {7'd0, m_state == S_RUN});
        check("cyc_expired", {7'd0, expired},   {7'd0, m_state == S_EXP});
        check("cyc_blink",   {7'd0, blink},     {7'd0, m_blink});
        check("cyc_field",   {7'd0, set_field}, {7'd0, m_field});
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic press_set(input logic [7:0] v);
        sw = v;
        key_set_n = 1'b0;
        cyc(2);
        key_set_n = 1'b1;
        cyc(5);
    endtask

    task automatic press_tog();
        key_tog_n = 1'b0;
        cyc(2);
        key_tog_n = 1'b1;
        cyc(5);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            cyc(1);
        end
    endtask

    initial begin
        reset     = 1'b1;
        tick      = 1'b0;
        key_set_n = 1'b1;
        key_tog_n = 1'b1;
        sw        = 8'h00;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        check("rst_min",   min_bcd,           8'h00);
        check("rst_sec",   sec_bcd,           8'h00);
        check("rst_run",   {7'd0, running},   8'h00);
        check("rst_field", {7'd0, set_field}, 8'h00);

        // Loads and clamping
        press_set(8'h45);
        press_set(8'h02);
        check("load_min",   min_bcd,           8'h02);
        check("load_sec",   sec_bcd,           8'h45);
        check("load_field", {7'd0, set_field}, 8'h00);
        press_set(8'h7C);
        check("clamp_sec",  sec_bcd,           8'h59);
        check("clamp_field",{7'd0, set_field}, 8'h01);
        press_set(8'h01);
        press_set(8'h00);
        press_set(8'h01);
        check("set_0100", {min_bcd, sec_bcd} == 16'h0100 ? 8'h01 : 8'h00, 8'h01);

        // Countdown to expiry
        press_tog();
        check("run_on", {7'd0, running}, 8'h01);
        tick_n(1);
        check("dec_min", min_bcd, 8'h00);
        check("dec_sec", sec_bcd, 8'h59);
        tick_n(59);
        check("exp_sec", sec_bcd,         8'h00);
        check("exp_flag",{7'd0, expired}, 8'h01);
        check("exp_run", {7'd0, running}, 8'h00);

        // Blink in EXPIRED
        tick_n(2);
        check("blink_1", {7'd0, blink}, 8'h01);
        tick_n(2);
        check("blink_2", {7'd0, blink}, 8'h00);
        press_set(8'h10);
        check("exp_set_idle", {7'd0, expired}, 8'h00);
        check("exp_set_sec",  sec_bcd,         8'h10);

        // Tick and toggle together in RUN
        press_tog();
        key_tog_n = 1'b0;
        cyc(2);
        key_tog_n = 1'b1;
        cyc(1);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(2);
        check("tt_run", {7'd0, running}, 8'h00);
        check("tt_sec", sec_bcd,         8'h10);
        tick_n(3);
        check("pause_sec", sec_bcd, 8'h10);

        // Async reset mid-run at 03:27
        press_set(8'h03);
        press_set(8'h27);
        press_tog();
        check("pre_rst_min", min_bcd, 8'h03);
        @(posedge CLOCK_50);
        #3 reset = 1'b1;
        #1;
        check("arst_min",   min_bcd,           8'h00);
        check("arst_sec",   sec_bcd,           8'h00);
        check("arst_run",   {7'd0, running},   8'h00);
        check("arst_field", {7'd0, set_field}, 8'h00);
        cyc(2);
        reset = 1'b0;
        cyc(1);

        // Toggle at 00:00 stays idle; one-cycle bounce gives one pulse
        press_tog();
        check("zero_tog", {7'd0, running}, 8'h00);
        sw = 8'h05;
        key_set_n = 1'b0;
        cyc(1);
        key_set_n = 1'b1;
        cyc(6);
        check("bounce_sec",   sec_bcd,           8'h05);
        check("bounce_min",   min_bcd,           8'h00);
        check("bounce_field", {7'd0, set_field}, 8'h01);

        // Randomized phase
        for (int i = 0; i < 5000; i++) begin
            tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) key_set_n = ~key_set_n;
            if ($urandom_range(0, 14) == 0) key_tog_n = ~key_tog_n;
            if ($urandom_range(0, 7) == 0) begin
                sw[7:4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
                sw[3:0] = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b1;
                cyc(1);
                reset = 1'b0;
            end
            cyc(1);
        end
        tick = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
